btn_gesture_decoder: RTL
========================

Name: btn_gesture_decoder

Overview:
- Input-side counterpart to the LED sequencer family. The sequencer turns elapsed time into LED patterns; this block measures time on a raw board button and decodes the presses into gesture events: short press, long press and double click.
- Sits between a raw board button pin and the mode/speed control logic of a top level.
- Contains its own 2-FF synchroniser and debouncer, so it connects directly to a pin.

Parameters:
CLK_HZ, 125_000_000, system clock frequency; sets ms tick period (CLK_HZ/1000 cycles)
DEBOUNCE_MS, 10, time the synchronised input must be stable before the debounced level changes
LONG_MS, 1000, hold time at or above which a press is a long press
DOUBLE_GAP_MS, 300, maximum release gap between two presses for a double click

Ports:
clk  input  1  system clock, 125 MHz
rst_n  input  1  reset; synchronous, active-low
btn_in  input  1  raw asynchronous button level, 1 = pressed
short_pulse  output  1  one-cycle pulse: single short press confirmed
long_pulse  output  1  one-cycle pulse: press held for LONG_MS
double_pulse  output  1  one-cycle pulse: double click confirmed
hold_active  output  1  high while a long press is still held
press_ms  output  16  duration in ms of the most recent completed first press; saturates at 65535

Behaviour:
- Reset: synchronous, active-low. Sampled on the clk rising edge.
- Values while rst_n = 0: all outputs 0, FSM in IDLE, all counters 0, synchroniser and debounced level 0.
- Reset mid-gesture aborts the gesture with no event.
- Synchroniser: 2 FFs; sync = second stage.
- Debouncer: cycle counter. Clears whenever sync == db_level. Increments while they differ. When it reaches DEBOUNCE_MS*CLK_HZ/1000-1, db_level <= sync and the counter clears. A glitch shorter than the window never changes db_level.
- db_rise / db_fall: one-cycle strobes on db_level transitions.
- ms_tick: free-running counter 0..CLK_HZ/1000-1, pulses at the terminal count. Not restarted by presses, so durations are quantised to -0/+1 ms.
- dur: 16-bit saturating ms counter. Cleared on every FSM state entry; increments on ms_tick.
- FSM states and transitions, evaluated on each clk edge:
  - IDLE: db_rise -> PRESS1.
  - PRESS1:
    - db_fall -> GAP; press_ms <= dur.
    - else when ms_tick and dur == LONG_MS-1 -> LONG_HELD; long_pulse = 1 for that cycle.
  - GAP:
    - db_rise -> PRESS2.
    - else when ms_tick and dur == DOUBLE_GAP_MS-1 -> IDLE; short_pulse = 1.
  - PRESS2: db_fall -> IDLE; double_pulse = 1. Holding has no long effect in PRESS2.
  - LONG_HELD: hold_active = 1; db_fall -> IDLE. press_ms is not updated for long presses.
- Simultaneous events: a db edge in the same cycle as a threshold ms_tick takes precedence. In PRESS1 the release wins; in GAP the second press wins.
- Illegal state encoding -> IDLE, no pulse.
- Event pulses are registered and mutually exclusive; at most one per gesture.
- Latency from a debounced edge to an event: 1 cycle. End-to-end: 2 sync cycles + debounce window + 1 cycle.
- press_ms holds its value until the next completed first press or reset.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=10_000 (10 cycles/ms), DEBOUNCE_MS=2, LONG_MS=50, DOUBLE_GAP_MS=20.
- Reset: hold rst_n=0 for 5 cycles while btn_in=1 -> all outputs 0. After release, db_level rises about 22 cycles later and the FSM reaches PRESS1.
- Short press: press 10 ms, release -> press_ms=10±1. short_pulse exactly once, 20±1 ms after the debounced release. No other pulse.
- Long press: hold 80 ms -> long_pulse once at 50±1 ms after db_rise. hold_active high from then until the cycle after db_fall. No short_pulse after release.
- Double click: press 5 ms, gap 10 ms, press 5 ms -> double_pulse once, one cycle after the second db_fall. short_pulse never asserted.
- Bounce and abort:
  - 5-cycle glitches on btn_in -> db_level never changes, no events.
  - rst_n=0 for 1 cycle during GAP -> FSM returns to IDLE with no short_pulse; press_ms=0.

Source files
------------

// File: rtl/btn_gesture_decoder.sv
// rtl/btn_gesture_decoder.sv - raw button to short/long/double-click gesture events
// Synchroniser, debouncer, free-running ms tick and gesture FSM in one block.
module btn_gesture_decoder #(
  parameter int CLK_HZ        = 125_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_MS       = 1000,
  parameter int DOUBLE_GAP_MS = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_in,
  output logic        short_pulse,
  output logic        long_pulse,
  output logic        double_pulse,
  output logic        hold_active,
  output logic [15:0] press_ms
);

  localparam int TICK_CYC = CLK_HZ / 1000;
  localparam int DB_CYC   = int'((longint'(DEBOUNCE_MS) * longint'(CLK_HZ)) / 1000);
  localparam int TW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int DW       = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
  localparam logic [15:0]   LONG_LAST = 16'(LONG_MS - 1);
  localparam logic [15:0]   GAP_LAST  = 16'(DOUBLE_GAP_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_GAP       = 3'd2,
    S_PRESS2    = 3'd3,
    S_LONG_HELD = 3'd4
  } state_e;

  logic          sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_level_q, db_level_d, db_prev_q;
  logic [TW-1:0] tick_cnt_q;
  logic [15:0]   dur_q, dur_d;
  logic [15:0]   press_q, press_d;
  state_e        state_q, state_d;
  logic          short_q, short_d, long_q, long_d, dbl_q, dbl_d;
  logic          db_rise, db_fall, ms_tick;

  assign db_rise = db_level_q & ~db_prev_q;
  assign db_fall = ~db_level_q & db_prev_q;
  assign ms_tick = (tick_cnt_q == TICK_LAST);

  // Any disagreement with the debounced level must persist for the whole window.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (sync2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_d = sync2_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    press_d = press_q;
    case (state_q)
      S_IDLE: begin
        if (db_rise) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (db_fall) begin
          state_d = S_GAP;
          press_d = dur_q;
        end else if (ms_tick && dur_q == LONG_LAST) begin
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (db_rise) begin
          state_d = S_PRESS2;
        end else if (ms_tick && dur_q == GAP_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_PRESS2: begin
        if (db_fall) begin
          state_d = S_IDLE;
          dbl_d   = 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (db_fall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Duration restarts on every state change, including IDLE.
  always_comb begin
    dur_d = dur_q;
    if (state_d != state_q) begin
      dur_d = '0;
    end else if (ms_tick && dur_q != 16'hFFFF) begin
      dur_d = dur_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      tick_cnt_q <= '0;
      dur_q      <= '0;
      press_q    <= '0;
      state_q    <= S_IDLE;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      dbl_q      <= 1'b0;
    end else begin
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
      tick_cnt_q <= ms_tick ? '0 : tick_cnt_q + 1'b1;
      dur_q      <= dur_d;
      press_q    <= press_d;
      state_q    <= state_d;
      short_q    <= short_d;
      long_q     <= long_d;
      dbl_q      <= dbl_d;
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign double_pulse = dbl_q;
  assign hold_active  = (state_q == S_LONG_HELD);
  assign press_ms     = press_q;

endmodule
